// File: rtl/implication_checker_pkg.sv
// rtl/implication_checker_pkg.sv - shared types and parameter defaults for the implication checker
package implication_checker_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chk_state_e;

    localparam int DEF_NCH   = 4;
    localparam int DEF_WIN_W = 4;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/impl_chk_channel.sv
// rtl/impl_chk_channel.sv - one implication channel: FSM, window counter, pass/fail counters, sticky fail
module impl_chk_channel
    import implication_checker_pkg::*;
#(
    parameter int WIN_W = DEF_WIN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clr,
    input  logic             ante,
    input  logic             cons,
    input  logic [WIN_W-1:0] win,
    output logic             busy,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic             fail_sticky,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    chk_state_e       state;
    chk_state_e       state_nxt;
    logic [WIN_W-1:0] remain;
    logic [WIN_W-1:0] remain_nxt;
    logic             pass_nxt;
    logic             fail_nxt;

    // remain holds the cycles left in the window, loaded once at the antecedent,
    // so later changes on win cannot disturb an attempt in flight.
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        pass_nxt   = 1'b0;
        fail_nxt   = 1'b0;
        if (!enable) begin
            state_nxt  = IDLE;
            remain_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ante) begin
                        if (win == '0) begin
                            pass_nxt = cons;
                            fail_nxt = ~cons;
                        end else begin
                            state_nxt  = WAIT;
                            remain_nxt = win;
                        end
                    end
                end
                WAIT: begin
                    if (cons) begin
                        pass_nxt   = 1'b1;
                        state_nxt  = IDLE;
                        remain_nxt = '0;
                    end else if (remain == WIN_W'(1)) begin
                        fail_nxt   = 1'b1;
                        state_nxt  = IDLE;
                        remain_nxt = '0;
                    end else begin
                        remain_nxt = remain - WIN_W'(1);
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    remain_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remain     <= '0;
            busy       <= 1'b0;
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            remain     <= remain_nxt;
            busy       <= (state_nxt == WAIT);
            pass_pulse <= pass_nxt;
            fail_pulse <= fail_nxt;
        end
    end

    // Counters move on the same edge as their pulse; a clear that coincides with
    // a pulse leaves that one event recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            fail_sticky <= 1'b0;
        end else begin
            if (clr) begin
                pass_cnt <= CNT_W'(pass_nxt);
            end else if (pass_nxt && (pass_cnt != '1)) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end

            if (clr) begin
                fail_cnt <= CNT_W'(fail_nxt);
            end else if (fail_nxt && (fail_cnt != '1)) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
            end

            fail_sticky <= (fail_sticky & ~clr) | fail_nxt;
        end
    end

endmodule

// File: rtl/implication_checker.sv
// rtl/implication_checker.sv - array of independent bounded-window implication checkers
module implication_checker
    import implication_checker_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int WIN_W = DEF_WIN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clr,
    input  logic [NCH-1:0]       ante,
    input  logic [NCH-1:0]       cons,
    input  logic [NCH*WIN_W-1:0] win,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       pass_pulse,
    output logic [NCH-1:0]       fail_pulse,
    output logic [NCH-1:0]       fail_sticky,
    output logic [NCH*CNT_W-1:0] pass_cnt,
    output logic [NCH*CNT_W-1:0] fail_cnt
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        impl_chk_channel #(
            .WIN_W (WIN_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable      (enable),
            .clr         (clr),
            .ante        (ante[g]),
            .cons        (cons[g]),
            .win         (win[g*WIN_W +: WIN_W]),
            .busy        (busy[g]),
            .pass_pulse  (pass_pulse[g]),
            .fail_pulse  (fail_pulse[g]),
            .fail_sticky (fail_sticky[g]),
            .pass_cnt    (pass_cnt[g*CNT_W +: CNT_W]),
            .fail_cnt    (fail_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_implication_checker.sv
// tb/tb_implication_checker.sv - directed scoreboard bench for implication_checker
module tb_implication_checker;

    localparam int NCH   = 4;
    localparam int WIN_W = 4;
    localparam int CNT_W = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic                 clr;
    logic [NCH-1:0]       ante;
    logic [NCH-1:0]       cons;
    logic [NCH*WIN_W-1:0] win;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       pass_pulse;
    logic [NCH-1:0]       fail_pulse;
    logic [NCH-1:0]       fail_sticky;
    logic [NCH*CNT_W-1:0] pass_cnt;
    logic [NCH*CNT_W-1:0] fail_cnt;

    typedef struct {
        int ch;
        bit is_fail;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    implication_checker #(
        .NCH   (NCH),
        .WIN_W (WIN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clr         (clr),
        .ante        (ante),
        .cons        (cons),
        .win         (win),
        .busy        (busy),
        .pass_pulse  (pass_pulse),
        .fail_pulse  (fail_pulse),
        .fail_sticky (fail_sticky),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input int ch, input bit is_fail, input int lat);
        exp_t e;
        e.ch      = ch;
        e.is_fail = is_fail;
        e.due     = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pcnt(input int ch);
        return 32'(pass_cnt[ch*CNT_W +: CNT_W]);
    endfunction

    function automatic logic [31:0] fcnt(input int ch);
        return 32'(fail_cnt[ch*CNT_W +: CNT_W]);
    endfunction

    // Every cycle the pulses must equal exactly the scoreboard entries due now.
    always @(negedge clk) begin : mon
        logic [NCH-1:0] ep;
        logic [NCH-1:0] ef;
        if (mon_on) begin
            ep = '0;
            ef = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    if (sb[i].is_fail) ef[sb[i].ch] = 1'b1;
                    else               ep[sb[i].ch] = 1'b1;
                    sb.delete(i);
                end
            end
            checks++;
            assert (pass_pulse === ep) else begin
                errors++;
                $error("FAIL pass_pulse observed=%b expected=%b (cycle %0d)", pass_pulse, ep, cyc);
            end
            checks++;
            assert (fail_pulse === ef) else begin
                errors++;
                $error("FAIL fail_pulse observed=%b expected=%b (cycle %0d)", fail_pulse, ef, cyc);
            end
            checks++;
            assert ((pass_pulse & fail_pulse) === '0) else begin
                errors++;
                $error("FAIL pulse_exclusive observed=%b expected=0 (cycle %0d)", pass_pulse & fail_pulse, cyc);
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        clr    = 1'b0;
        ante   = '0;
        cons   = '0;
        win    = '0;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_pass_pulse", 32'(pass_pulse), 0);
        check("rst_fail_pulse", 32'(fail_pulse), 0);
        check("rst_sticky", 32'(fail_sticky), 0);
        check("rst_pass_cnt", 32'(pass_cnt), 0);
        check("rst_fail_cnt", 32'(fail_cnt), 0);
        repeat (2) tick();
        rst_n  = 1'b1;
        enable = 1'b1;
        mon_on = 1'b1;
        tick();

        // ch0 overlapping check, pass then fail
        ante[0] = 1'b1; cons[0] = 1'b1;
        expect_evt(0, 1'b0, 1);
        tick();
        ante[0] = 1'b0; cons[0] = 1'b0;
        check("ch0_pass_cnt", pcnt(0), 1);
        check("ch0_busy_overlap", 32'(busy[0]), 0);
        tick();
        ante[0] = 1'b1;
        expect_evt(0, 1'b1, 1);
        tick();
        ante[0] = 1'b0;
        check("ch0_fail_cnt", fcnt(0), 1);
        check("ch0_sticky", 32'(fail_sticky[0]), 1);
        tick();
        check("ch0_sticky_hold", 32'(fail_sticky[0]), 1);

        // ch1 window 3: cons in antecedent cycle ignored, win changed mid-attempt, pass on last cycle
        win[4 +: 4] = 4'd3;
        ante[1] = 1'b1; cons[1] = 1'b1;
        expect_evt(1, 1'b0, 4);
        tick();
        ante[1] = 1'b0; cons[1] = 1'b0;
        win[4 +: 4] = 4'd1;
        check("ch1_busy_k1", 32'(busy[1]), 1);
        tick();
        check("ch1_busy_k2", 32'(busy[1]), 1);
        tick();
        check("ch1_busy_k3", 32'(busy[1]), 1);
        cons[1] = 1'b1;
        tick();
        cons[1] = 1'b0;
        check("ch1_busy_done", 32'(busy[1]), 0);
        check("ch1_pass_cnt", pcnt(1), 1);

        // ch1 window 3 timeout
        win[4 +: 4] = 4'd3;
        ante[1] = 1'b1;
        expect_evt(1, 1'b1, 4);
        tick();
        ante[1] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("ch1_to_busy_k%0d", k), 32'(busy[1]), 1);
            tick();
        end
        check("ch1_to_busy_done", 32'(busy[1]), 0);
        check("ch1_fail_cnt", fcnt(1), 1);

        // ch2 window 2 with ante held: only first attempt, next at first IDLE cycle
        win[8 +: 4] = 4'd2;
        ante[2] = 1'b1;
        expect_evt(2, 1'b1, 3);
        expect_evt(2, 1'b1, 6);
        tick();
        check("ch2_busy_c1", 32'(busy[2]), 1);
        tick();
        tick();
        check("ch2_idle_c3", 32'(busy[2]), 0);
        tick();
        ante[2] = 1'b0;
        check("ch2_rearm_c4", 32'(busy[2]), 1);
        tick();
        tick();
        check("ch2_fail_cnt", fcnt(2), 2);

        // ch3 saturating fail counter, then clear coinciding with a fail
        ante[3] = 1'b1; cons[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_evt(3, 1'b1, 1);
            tick();
        end
        check("ch3_fail_sat", fcnt(3), 3);
        clr = 1'b1;
        expect_evt(3, 1'b1, 1);
        tick();
        clr = 1'b0;
        ante[3] = 1'b0;
        check("ch3_clr_fail_cnt", fcnt(3), 1);
        check("ch3_clr_sticky", 32'(fail_sticky[3]), 1);
        check("ch0_clr_sticky", 32'(fail_sticky[0]), 0);
        check("ch0_clr_fail_cnt", fcnt(0), 0);
        check("ch1_clr_pass_cnt", pcnt(1), 0);

        // enable dropped mid-WAIT on ch1
        ante[1] = 1'b1;
        tick();
        ante[1] = 1'b0;
        check("en_busy_before", 32'(busy[1]), 1);
        enable = 1'b0;
        tick();
        check("en_busy_after", 32'(busy[1]), 0);
        check("en_cnt_hold", fcnt(3), 1);
        check("en_sticky_hold", 32'(fail_sticky[3]), 1);
        enable = 1'b1;
        repeat (5) tick();
        check("en_no_fail_cnt", fcnt(1), 0);

        // reset pulse mid-WAIT on ch1
        ante[1] = 1'b1;
        tick();
        ante[1] = 1'b0;
        check("rst_mid_busy_before", 32'(busy[1]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy_now", 32'(busy[1]), 0);
        check("rst_mid_cnt", fcnt(3), 0);
        check("rst_mid_sticky", 32'(fail_sticky), 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("rst_after_busy", 32'(busy[1]), 0);
        check("rst_after_fail_cnt", fcnt(1), 0);
        check("rst_after_pass_cnt", pcnt(1), 0);

        // evaluation resumes after reset
        ante[0] = 1'b1; cons[0] = 1'b1;
        expect_evt(0, 1'b0, 1);
        tick();
        ante[0] = 1'b0; cons[0] = 1'b0;
        check("post_rst_pass_cnt", pcnt(0), 1);
        tick();

        check("sb_drained", 32'(sb.size()), 0);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
